dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the data-memory arbiter and the memory.
// The arbiter connects through the slave modport; the environment connects through master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int BE_W   = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [BE_W-1:0]   cpu_be;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [BE_W-1:0]   dbg_be;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
        output dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be,
        input  dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) round-robin arbiter in front of a single-ported data memory.
// Each access takes three cycles: IDLE (grant + capture), ISSUE (mem strobe), RESP (ack).
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int BE_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        bus_if
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic CPU = 1'b0;
    localparam logic DBG = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;

    logic any_req;
    logic grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= CPU;
            last_grant_q <= DBG;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;

        bus_if.mem_en    = 1'b0;
        bus_if.mem_we    = 1'b0;
        bus_if.mem_addr  = '0;
        bus_if.mem_wdata = '0;
        bus_if.mem_be    = '0;
        bus_if.cpu_ack   = 1'b0;
        bus_if.cpu_rdata = '0;
        bus_if.dbg_ack   = 1'b0;
        bus_if.dbg_rdata = '0;

        // On a tie the port that lost last time wins; a lone requester always wins.
        any_req = bus_if.cpu_req | bus_if.dbg_req;
        if (bus_if.cpu_req && bus_if.dbg_req) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus_if.cpu_req ? CPU : DBG;
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = ISSUE;
                    owner_d      = grant;
                    last_grant_d = grant;
                    if (grant == DBG) begin
                        we_d    = bus_if.dbg_we;
                        addr_d  = bus_if.dbg_addr;
                        wdata_d = bus_if.dbg_wdata;
                        be_d    = bus_if.dbg_be;
                    end else begin
                        we_d    = bus_if.cpu_we;
                        addr_d  = bus_if.cpu_addr;
                        wdata_d = bus_if.cpu_wdata;
                        be_d    = bus_if.cpu_be;
                    end
                end
            end
            ISSUE: begin
                bus_if.mem_en    = 1'b1;
                bus_if.mem_we    = we_q;
                bus_if.mem_addr  = addr_q;
                bus_if.mem_wdata = wdata_q;
                bus_if.mem_be    = be_q;
                state_d          = RESP;
            end
            RESP: begin
                // Memory data is returned for writes too; requesters simply ignore it.
                if (owner_q == DBG) begin
                    bus_if.dbg_ack   = 1'b1;
                    bus_if.dbg_rdata = bus_if.mem_rdata;
                end else begin
                    bus_if.cpu_ack   = 1'b1;
                    bus_if.cpu_rdata = bus_if.mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
